wb_irq_ctrl: RTL and testbench
==============================

// Module: wb_irq_ctrl
// PURPOSE
//  Wishbone slave interrupt controller for the LM32 SoC; sits directly downstream of the GPIO irq line
//  and of the other peripheral interrupt sources.
//  Synchronises NUM_SRC raw request lines, captures them per source (edge or level), masks them, and
//  drives one registered interrupt line to the CPU.
//  Firmware identifies sources by reading PENDING/STATUS and clears events by write-1-to-clear.
// PARAMETERS
//  NUM_SRC       8   number of interrupt sources, 1..32
//  wb_dat_width  32  Wishbone data width
//  wb_adr_width  32  Wishbone address width (byte address)
// PORTS
//  clk       in   1             system clock
//  rst       in   1             synchronous reset, active-low (0 = reset)
//  wb_adr_i  in   wb_adr_width  byte address; decode uses [4:2] only
//  wb_dat_i  in   wb_dat_width  write data
//  wb_we_i   in   1             1 = write, 0 = read
//  wb_cyc_i  in   1             bus cycle valid
//  wb_stb_i  in   1             strobe
//  wb_ack_o  out  1             transfer acknowledge
//  wb_dat_o  out  wb_dat_width  read data, registered
//  src_i     in   NUM_SRC       raw interrupt requests, asynchronous to clk
//  irq_o     out  1             interrupt to CPU, registered, active-high
// BEHAVIOUR
//  Reset (rst==0 at posedge): PENDING=0, MASK=0, MODE=all 1 (edge), sync flops=0, ack=0, wb_dat_o=0, irq_o=0.
//  Sync: 2-flop synchroniser per source (s1, s2); s3 holds the previous s2 for edge detection.
//  Registers, selected by wb_adr_i[4:2]:
//   000 PENDING  R/W1C  captured events
//   001 MASK     R/W    1 = source enabled
//   010 STATUS   RO     PENDING & MASK
//   011 MODE     R/W    1 = rising-edge capture, 0 = level
//   1xx          reads 0, writes ignored (except VECTOR, see CONFIGURATION)
//  Register bits at and above NUM_SRC: read 0, writes ignored.
//  Capture per bit i, every cycle:
//   edge:  set when s2 & ~s3; cleared by a write to PENDING with wb_dat_i[i]=1.
//   level: PENDING[i] <= s2, recomputed every cycle; W1C has no lasting effect while the source is high.
//   Set and W1C on the same bit in the same cycle: set wins, so no event is lost.
//   A MODE change takes effect on the next cycle; PENDING is not cleared by it.
//  irq_o <= |(PENDING & MASK), registered.
//   Latency: src_i rising before edge k -> PENDING at edge k+2 -> irq_o at edge k+3.
//   Edge capture requires src_i to stay high for >=2 clk to be guaranteed.
//  Wishbone handshake (classic, single-cycle registered ack):
//   wb_ack_o = wb_stb_i & wb_cyc_i & ack.
//   On stb&cyc&~ack: ack<=1; on the next cycle ack<=0. Transfers therefore complete every 2 cycles.
//   Read: wb_dat_o loaded in the same edge that sets ack, so data is valid while wb_ack_o=1.
//    wb_dat_o holds its value between reads.
//   Write: register updated at the edge that sets ack.
//   Dropping cyc/stb mid-transfer: wb_ack_o goes low combinationally; ack self-clears next cycle;
//    no register side effect beyond an already-performed write.
//  Reset asserted mid-transfer: ack and all state return to reset values at that edge; no ack is issued.
// CONFIGURATION
//  WB_IRQ_CTRL_VECTOR_EN defined:
//   Adds VECTOR at adr[4:2]=100, read-only.
//   bit31 = |STATUS; [4:0] = index of the lowest-numbered set STATUS bit (0 when none); other bits 0.
//   Computed combinationally from STATUS and registered into wb_dat_o on read.
//  WB_IRQ_CTRL_VECTOR_EN undefined:
//   adr 100 reads 0 and no priority encoder is built.
// TESTING
//  Reset: hold rst=0 for 3 clk -> irq_o=0, wb_ack_o=0, reads give PENDING=0, MASK=0, MODE=0xFF, STATUS=0.
//  Edge capture: MASK=0x01, pulse src_i[0] high for 4 clk
//   -> irq_o=1 three edges after first sample, PENDING=0x01.
//   -> write PENDING=0x01 -> irq_o=0 two edges later.
//  Masking: MASK=0, pulse src_i[5] -> PENDING=0x20, STATUS=0, irq_o stays 0
//   -> write MASK=0x20 -> irq_o=1 the cycle after the write ack.
//  Level mode: MODE=0xFE, MASK=0x01, hold src_i[0]=1 -> W1C of 0x01 leaves PENDING=0x01 and irq_o=1
//   -> drop src_i[0] -> PENDING=0x00 and irq_o=0 within 4 clk.
//  Collision: time a W1C of PENDING bit 2 in the same cycle as a new rising edge on s2[2]
//   -> PENDING[2]=1 afterwards.
//  Bus: back-to-back reads with cyc/stb held -> ack pattern 1,0,1,0.
//   Read adr 0x1C -> 0. With WB_IRQ_CTRL_VECTOR_EN: STATUS=0x28 -> VECTOR=0x80000003.

Source files
------------

// File: rtl/wb_irq_ctrl.sv
// Wishbone interrupt controller: synchronises NUM_SRC request lines, captures them per source (edge or level),
// and drives a masked, registered irq_o. Optional VECTOR register when WB_IRQ_CTRL_VECTOR_EN is defined.
module wb_irq_ctrl #(
    parameter int unsigned NUM_SRC      = 8,
    parameter int unsigned wb_dat_width = 32,
    parameter int unsigned wb_adr_width = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [wb_adr_width-1:0] wb_adr_i,
    input  logic [wb_dat_width-1:0] wb_dat_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    output logic                    wb_ack_o,
    output logic [wb_dat_width-1:0] wb_dat_o,
    input  logic [NUM_SRC-1:0]      src_i,
    output logic                    irq_o
);

    localparam logic [2:0] ADR_PENDING = 3'b000;
    localparam logic [2:0] ADR_MASK    = 3'b001;
    localparam logic [2:0] ADR_STATUS  = 3'b010;
    localparam logic [2:0] ADR_MODE    = 3'b011;
`ifdef WB_IRQ_CTRL_VECTOR_EN
    localparam logic [2:0]  ADR_VECTOR = 3'b100;
    localparam int unsigned VEC_IDX_W  = 5;
`endif

    logic [NUM_SRC-1:0]      s1, s2, s3;
    logic [NUM_SRC-1:0]      pending, mask, mode;
    logic [NUM_SRC-1:0]      pending_nxt, mask_nxt, mode_nxt;
    logic [NUM_SRC-1:0]      status, w1c, wr_bits;
    logic                    ack, req, wr;
    logic [2:0]              reg_sel;
    logic [wb_dat_width-1:0] rd_data, dat_nxt;
    logic                    unused_bits;

    assign req      = wb_stb_i & wb_cyc_i & ~ack;
    assign wr       = req & wb_we_i;
    assign reg_sel  = wb_adr_i[4:2];
    assign wr_bits  = wb_dat_i[NUM_SRC-1:0];
    assign wb_ack_o = wb_stb_i & wb_cyc_i & ack;
    assign status   = pending & mask;

    // Only adr[4:2] and the low NUM_SRC data bits carry meaning
    assign unused_bits = ^{wb_adr_i, wb_dat_i};

`ifdef WB_IRQ_CTRL_VECTOR_EN
    logic [VEC_IDX_W-1:0] vec_idx;
    logic [31:0]          vec_word;

    // Lowest-numbered active source wins: scan downwards so the last hit is the lowest index
    always_comb begin
        vec_idx = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (status[i]) vec_idx = VEC_IDX_W'(i);
        end
        vec_word = {|status, 26'd0, vec_idx};
    end
`endif

    // Read mux
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            ADR_PENDING: rd_data = wb_dat_width'(pending);
            ADR_MASK:    rd_data = wb_dat_width'(mask);
            ADR_STATUS:  rd_data = wb_dat_width'(status);
            ADR_MODE:    rd_data = wb_dat_width'(mode);
`ifdef WB_IRQ_CTRL_VECTOR_EN
            ADR_VECTOR:  rd_data = wb_dat_width'(vec_word);
`endif
            default:     rd_data = '0;
        endcase
    end

    // Next-state: capture (edge sets beat W1C clears), register writes, read data load
    always_comb begin
        w1c      = '0;
        mask_nxt = mask;
        mode_nxt = mode;
        dat_nxt  = wb_dat_o;
        if (wr) begin
            case (reg_sel)
                ADR_PENDING: w1c      = wr_bits;
                ADR_MASK:    mask_nxt = wr_bits;
                ADR_MODE:    mode_nxt = wr_bits;
                default:     ;
            endcase
        end
        if (req && !wb_we_i) dat_nxt = rd_data;
        pending_nxt = (mode & ((s2 & ~s3) | (pending & ~w1c))) | (~mode & s2);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            pending  <= '0;
            mask     <= '0;
            mode     <= '1;
            ack      <= 1'b0;
            wb_dat_o <= '0;
            irq_o    <= 1'b0;
        end else begin
            s1       <= src_i;
            s2       <= s1;
            s3       <= s2;
            pending  <= pending_nxt;
            mask     <= mask_nxt;
            mode     <= mode_nxt;
            ack      <= req;
            wb_dat_o <= dat_nxt;
            irq_o    <= |status;
        end
    end

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Directed self-checking bench for wb_irq_ctrl; honours WB_IRQ_CTRL_VECTOR_EN for the VECTOR check.
module tb_wb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_adr, wb_dat_i, wb_dat_o;
    logic        wb_we, wb_cyc, wb_stb, wb_ack;
    logic [7:0]  src;
    logic        irq;
    logic [3:0]  pat;
    int          checks = 0;
    int          errors = 0;

    wb_irq_ctrl #(.NUM_SRC(8), .wb_dat_width(32), .wb_adr_width(32)) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_i), .wb_we_i(wb_we),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_ack_o(wb_ack), .wb_dat_o(wb_dat_o),
        .src_i(src), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       output logic [31:0] rdat);
        int n;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!wb_ack && n < 8);
        if (!wb_ack) begin
            checks++;
            errors++;
            $error("FAIL bus_timeout adr %08h: observed no ack expected ack", adr);
        end
        rdat   = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] junk;
        bus(1'b1, adr, dat, junk);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, adr, 32'h0, r);
        chk(tag, r, exp);
    endtask

    initial begin
        // Reset with a bus request pending: no ack may appear
        rst = 1'b0; src = '0; wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
        wb_adr = '0; wb_dat_i = '0; pat = '0;
        tick(3);
        chk("rst_ack", 32'(wb_ack), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0;
        tick(1);
        rd_chk("rst_pending", 32'h00, 32'h00);
        rd_chk("rst_mask",    32'h04, 32'h00);
        rd_chk("rst_mode",    32'h0C, 32'hFF);
        rd_chk("rst_status",  32'h08, 32'h00);

        // Edge capture, latency 3 edges from first sample
        wr(32'h04, 32'hFFFF_FF01);
        rd_chk("mask_upper_ignored", 32'h04, 32'h01);
        src[0] = 1'b1;
        tick(3);
        chk("edge_irq_early", 32'(irq), 32'h0);
        tick(1);
        chk("edge_irq", 32'(irq), 32'h1);
        src[0] = 1'b0;
        rd_chk("edge_pending", 32'h00, 32'h01);
        wr(32'h00, 32'h01);
        chk("w1c_irq_hold", 32'(irq), 32'h1);
        tick(1);
        chk("w1c_irq_clear", 32'(irq), 32'h0);
        rd_chk("w1c_pending", 32'h00, 32'h00);

        // Masking
        wr(32'h04, 32'h00);
        src[5] = 1'b1;
        tick(4);
        src[5] = 1'b0;
        tick(3);
        rd_chk("mask_pending", 32'h00, 32'h20);
        rd_chk("mask_status",  32'h08, 32'h00);
        chk("mask_irq", 32'(irq), 32'h0);
        wr(32'h04, 32'h20);
        chk("unmask_irq_hold", 32'(irq), 32'h0);
        tick(1);
        chk("unmask_irq", 32'(irq), 32'h1);
        wr(32'h00, 32'h20);
        wr(32'h08, 32'hFF);
        rd_chk("status_ro_mask", 32'h04, 32'h20);

        // Level mode on source 0
        wr(32'h0C, 32'hFE);
        wr(32'h04, 32'h01);
        src[0] = 1'b1;
        tick(4);
        wr(32'h00, 32'h01);
        rd_chk("level_pending", 32'h00, 32'h01);
        chk("level_irq", 32'(irq), 32'h1);
        src[0] = 1'b0;
        tick(4);
        chk("level_irq_drop", 32'(irq), 32'h0);
        rd_chk("level_pending_drop", 32'h00, 32'h00);

        // W1C lands on the same edge as a fresh rising edge of bit 2
        src[2] = 1'b1;
        tick(2);
        wr(32'h00, 32'h04);
        rd_chk("collision", 32'h00, 32'h04);
        src[2] = 1'b0;
        tick(3);
        wr(32'h00, 32'h04);
        rd_chk("collision_clear", 32'h00, 32'h00);

        // Back-to-back reads with cyc/stb held; unmapped address reads 0
        rd_chk("mask_level", 32'h04, 32'h01);
        tick(1);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h1C;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            pat = {pat[2:0], wb_ack};
        end
        chk("ack_pattern", 32'(pat), 32'hA);
        chk("unmapped_read", wb_dat_o, 32'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0;

        // Dropping strobe mid-transfer kills ack combinationally
        tick(1);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = 32'h04;
        tick(1);
        chk("mid_ack", 32'(wb_ack), 32'h1);
        wb_stb = 1'b0;
        #1;
        chk("mid_drop_ack", 32'(wb_ack), 32'h0);
        wb_cyc = 1'b0;
        tick(1);

        // STATUS 0x28 -> VECTOR
        wr(32'h04, 32'h28);
        src[3] = 1'b1; src[5] = 1'b1;
        tick(4);
        src = '0;
        tick(3);
        rd_chk("vec_status", 32'h08, 32'h28);
        chk("vec_irq", 32'(irq), 32'h1);
`ifdef WB_IRQ_CTRL_VECTOR_EN
        rd_chk("vector", 32'h10, 32'h8000_0003);
`else
        rd_chk("vector_off", 32'h10, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
